// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage MIPS core: stall/flush generation,
// ID/EX forwarding selects and the multi-cycle MULT/DIV occupancy sequencer.
module hazard_unit #(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned REG_AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              pcSrcD,
    input  logic              jumpD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeRegE,
    input  logic              regWriteE,
    input  logic              memToRegE,
    input  logic              mdStartE,
    input  logic [REG_AW-1:0] writeRegM,
    input  logic              regWriteM,
    input  logic              memToRegM,
    input  logic [REG_AW-1:0] writeRegW,
    input  logic              regWriteW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mdBusy,
    output logic              mdDone
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdState_t;

    mdState_t         state;
    mdState_t         stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    logic lwStall;
    logic brStall;
    logic mdBusyInt;
    logic stallAny;

    // $0 is hardwired, so it never carries a dependency
    function automatic logic regHit(input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwdSelE(input logic [REG_AW-1:0] src,
                                           input logic              wrM,
                                           input logic [REG_AW-1:0] dstM,
                                           input logic              wrW,
                                           input logic [REG_AW-1:0] dstW);
        logic [1:0] sel;
        sel = 2'b00;
        if (wrM && regHit(dstM, src)) begin
            sel = 2'b10;
        end else if (wrW && regHit(dstW, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // MULT/DIV sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // cnt holds the BUSY cycles still to go; the last one hands over to DONE
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (mdStartE) begin
                    if (MD_CYCLES > 2) begin
                        stateNext = BUSY;
                        cntNext   = CNT_W'(MD_CYCLES - 2);
                    end else begin
                        stateNext = DONE;
                        cntNext   = '0;
                    end
                end
            end
            BUSY: begin
                cntNext = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    stateNext = DONE;
                    cntNext   = '0;
                end
            end
            DONE: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Hazard detection against the instruction in ID
    always_comb begin
        lwStall   = memToRegE && (regHit(writeRegE, rsD) || regHit(writeRegE, rtD));
        brStall   = branchD &&
                    ((regWriteE && (regHit(writeRegE, rsD) || regHit(writeRegE, rtD))) ||
                     (memToRegM && (regHit(writeRegM, rsD) || regHit(writeRegM, rtD))));
        mdBusyInt = (state == BUSY) || ((state == IDLE) && mdStartE);
        stallAny  = lwStall || brStall || mdBusyInt;
    end

    // Output drive; everything is held low while reset is asserted
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        mdBusy    = 1'b0;
        mdDone    = 1'b0;
        if (!rst) begin
            stallF    = stallAny;
            stallD    = stallAny;
            stallE    = mdBusyInt;
            flushM    = mdBusyInt;
            flushE    = (lwStall || brStall) && !mdBusyInt;
            flushD    = (pcSrcD || jumpD) && !stallAny;
            forwardAD = regWriteM && regHit(writeRegM, rsD);
            forwardBD = regWriteM && regHit(writeRegM, rtD);
            forwardAE = fwdSelE(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardBE = fwdSelE(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
            mdBusy    = mdBusyInt;
            mdDone    = (state == DONE);
        end
    end

endmodule
